// File: rtl/matriz_scan_driver.sv
// Row-multiplexed scan driver for the 5x7 LED status matrix: resynchronises the divider's
// row/image selects, blanks between rows and swaps images only at frame boundaries.
module matriz_scan_driver #(
    parameter int ROWS         = 7,
    parameter int COLS         = 5,
    parameter int BLANK_CYCLES = 64,
    parameter int ROW_ACT_LOW  = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [2:0]             row_sel_in,
    input  logic                   img_sel_in,
    input  logic [ROWS*COLS-1:0]   img0_data,
    input  logic [ROWS*COLS-1:0]   img1_data,
    output logic [ROWS-1:0]        linhas,
    output logic [COLS-1:0]        colunas,
    output logic                   frame_start
);

    localparam int              CNT_W    = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [ROWS-1:0] LIN_OFF  = (ROW_ACT_LOW != 0) ? {ROWS{1'b1}} : {ROWS{1'b0}};

    typedef enum logic [1:0] {IDLE, BLANK, DRIVE, DARK} state_t;

    state_t           state, state_next;
    logic [2:0]       row_s1, row_s2, prev_row;
    logic             img_s1, img_s2;
    logic [1:0]       warm;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       cur_row, row_next;
    logic             img_latched, img_next;
    logic             frame_next;
    logic             row_chg;
    logic [ROWS*COLS-1:0] img_cur;
    logic [ROWS-1:0]  row_on;
    logic [COLS-1:0]  col_pick;
    logic [ROWS-1:0]  lin_next;
    logic [COLS-1:0]  col_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            row_s1      <= '0;
            row_s2      <= '0;
            prev_row    <= '0;
            img_s1      <= 1'b0;
            img_s2      <= 1'b0;
            warm        <= '0;
            state       <= IDLE;
            cnt         <= '0;
            cur_row     <= '0;
            img_latched <= 1'b0;
            linhas      <= LIN_OFF;
            colunas     <= '0;
            frame_start <= 1'b0;
        end else begin
            row_s1      <= row_sel_in;
            row_s2      <= row_s1;
            prev_row    <= row_s2;
            img_s1      <= img_sel_in;
            img_s2      <= img_s1;
            if (warm != 2'd3)
                warm <= warm + 2'd1;
            state       <= state_next;
            cnt         <= cnt_next;
            cur_row     <= row_next;
            img_latched <= img_next;
            linhas      <= lin_next;
            colunas     <= col_next;
            frame_start <= frame_next;
        end
    end

    // Change detection is held off until the cleared synchroniser has refilled, so a row
    // index that was already stable across reset does not count as a change.
    always_comb begin
        row_chg = (warm == 2'd3) && (row_s2 != prev_row);
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        row_next   = cur_row;
        img_next   = img_latched;
        frame_next = 1'b0;
        if (row_chg) begin
            state_next = BLANK;
            cnt_next   = CNT_LOAD;
            row_next   = row_s2;
            if (row_s2 == 3'd0) begin
                img_next   = img_s2;
                frame_next = 1'b1;
            end
        end else begin
            case (state)
                BLANK: begin
                    if (cnt == '0)
                        state_next = (int'(cur_row) < ROWS) ? DRIVE : DARK;
                    else
                        cnt_next = cnt - CNT_W'(1);
                end
                default: state_next = state;
            endcase
        end
    end

    always_comb begin
        img_cur  = img_latched ? img1_data : img0_data;
        row_on   = '0;
        col_pick = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (row_next == 3'(r)) begin
                row_on[r] = 1'b1;
                col_pick  = img_cur[r*COLS +: COLS];
            end
        end
    end

    always_comb begin
        lin_next = LIN_OFF;
        col_next = '0;
        if (state_next == DRIVE) begin
            lin_next = (ROW_ACT_LOW != 0) ? ~row_on : row_on;
            col_next = col_pick;
        end
    end

endmodule

// File: tb/tb_matriz_scan_driver.sv
// Bench for matriz_scan_driver: row/image vectors from a table, expected outputs queued with
// their due cycle and compared on the falling edge, plus glitch and reset sequences.
module tb_matriz_scan_driver;

    typedef struct {
        logic [2:0] row;
        logic       sel;
        logic [6:0] lin;
        logic [4:0] col;
        logic       fs;
    } vec_t;

    typedef struct {
        int         cyc;
        string      name;
        logic [6:0] lin;
        logic [4:0] col;
        logic       fs;
    } exp_t;

    localparam logic [6:0] OFF = 7'h7F;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  row_sel_in;
    logic        img_sel_in;
    logic [34:0] img0_data, img1_data;
    logic [6:0]  linhas;
    logic [4:0]  colunas;
    logic        frame_start;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   fs_count = 0;
    logic glitch_watch = 1'b0;
    logic ghost_seen = 1'b0;
    exp_t sb[$];
    vec_t vecs[11];
    logic [4:0] img0_rows[7];
    logic [4:0] img1_rows[7];

    matriz_scan_driver dut (
        .clock       (clock),
        .reset       (reset),
        .row_sel_in  (row_sel_in),
        .img_sel_in  (img_sel_in),
        .img0_data   (img0_data),
        .img1_data   (img1_data),
        .linhas      (linhas),
        .colunas     (colunas),
        .frame_start (frame_start)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pushExp(input int at, input string nm, input logic [6:0] l,
                           input logic [4:0] c, input logic f);
        exp_t e;
        e.cyc  = at;
        e.name = nm;
        e.lin  = l;
        e.col  = c;
        e.fs   = f;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        checks++;
        if (linhas !== e.lin || colunas !== e.col || frame_start !== e.fs) begin
            errors++;
            $display("[TB] FAIL %s @cyc %0d: got linhas=%b colunas=%b frame_start=%b, want linhas=%b colunas=%b frame_start=%b",
                     e.name, cyc, linhas, colunas, frame_start, e.lin, e.col, e.fs);
        end
    endtask

    // Image select settles first, then the row moves; the queued checks cover blank entry,
    // the last dead cycle and the first lit cycle.
    task automatic applyStimulus(input vec_t v, input string nm);
        int c;
        img_sel_in = v.sel;
        waitCycles(5);
        row_sel_in = v.row;
        c = cyc;
        pushExp(c + 3,  {nm, "_blank_entry"}, OFF, 5'h00, v.fs);
        pushExp(c + 4,  {nm, "_blank"},       OFF, 5'h00, 1'b0);
        pushExp(c + 66, {nm, "_dead_end"},    OFF, 5'h00, 1'b0);
        pushExp(c + 67, {nm, "_lit"},         v.lin, v.col, 1'b0);
    endtask

    always @(negedge clock) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc)
            checkOutput(sb.pop_front());
        if (frame_start === 1'b1)
            fs_count++;
        if (glitch_watch && linhas !== OFF && linhas !== 7'b1110111 && linhas !== 7'b1101111)
            ghost_seen = 1'b1;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit at cyc %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t g;
        int   c;

        img0_rows = '{5'h01, 5'h03, 5'h15, 5'h07, 5'h0F, 5'h1F, 5'h12};
        img1_rows = '{5'h1E, 5'h1C, 5'h0A, 5'h18, 5'h10, 5'h11, 5'h0D};
        for (int r = 0; r < 7; r++) begin
            img0_data[r*5 +: 5] = img0_rows[r];
            img1_data[r*5 +: 5] = img1_rows[r];
        end

        vecs[0]  = '{3'd1, 1'b0, 7'b1111101, 5'h03, 1'b0};
        vecs[1]  = '{3'd2, 1'b0, 7'b1111011, 5'h15, 1'b0};
        vecs[2]  = '{3'd3, 1'b0, 7'b1110111, 5'h07, 1'b0};
        vecs[3]  = '{3'd4, 1'b1, 7'b1101111, 5'h0F, 1'b0};
        vecs[4]  = '{3'd5, 1'b1, 7'b1011111, 5'h1F, 1'b0};
        vecs[5]  = '{3'd6, 1'b1, 7'b0111111, 5'h12, 1'b0};
        vecs[6]  = '{3'd7, 1'b1, 7'h7F,      5'h00, 1'b0};
        vecs[7]  = '{3'd0, 1'b1, 7'b1111110, 5'h1E, 1'b1};
        vecs[8]  = '{3'd1, 1'b0, 7'b1111101, 5'h1C, 1'b0};
        vecs[9]  = '{3'd2, 1'b0, 7'b1111011, 5'h0A, 1'b0};
        vecs[10] = '{3'd0, 1'b1, 7'b1111110, 5'h1E, 1'b1};

        reset      = 1'b1;
        row_sel_in = 3'd0;
        img_sel_in = 1'b0;
        pushExp(1,  "reset_state", OFF, 5'h00, 1'b0);
        pushExp(2,  "reset_hold",  OFF, 5'h00, 1'b0);
        pushExp(10, "idle_early",  OFF, 5'h00, 1'b0);
        pushExp(40, "idle_late",   OFF, 5'h00, 1'b0);
        waitCycles(2);
        reset = 1'b0;
        waitCycles(45);

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
            waitCycles(70);
        end

        g = '{3'd3, 1'b1, 7'b1110111, 5'h18, 1'b0};
        applyStimulus(g, "pre_glitch");
        waitCycles(70);
        glitch_watch = 1'b1;
        row_sel_in = 3'd7;
        waitCycles(1);
        row_sel_in = 3'd5;
        waitCycles(1);
        row_sel_in = 3'd4;
        c = cyc;
        pushExp(c + 3,  "glitch_blank",    OFF, 5'h00, 1'b0);
        pushExp(c + 66, "glitch_dead_end", OFF, 5'h00, 1'b0);
        pushExp(c + 67, "glitch_lit",      7'b1101111, 5'h10, 1'b0);
        waitCycles(70);
        glitch_watch = 1'b0;
        checks++;
        if (ghost_seen) begin
            errors++;
            $display("[TB] FAIL glitch_ghost: got a wrong row lit during glitch, want only rows 3/4 or dark");
        end

        g = '{3'd5, 1'b1, 7'b1011111, 5'h11, 1'b0};
        applyStimulus(g, "pre_reset");
        waitCycles(70);
        reset = 1'b1;
        c = cyc;
        pushExp(c + 1,  "reset_mid_drive", OFF, 5'h00, 1'b0);
        waitCycles(1);
        reset = 1'b0;
        pushExp(c + 40, "post_reset_idle", OFF, 5'h00, 1'b0);
        pushExp(c + 90, "post_reset_hold", OFF, 5'h00, 1'b0);
        waitCycles(95);
        g = '{3'd6, 1'b1, 7'b0111111, 5'h12, 1'b0};
        applyStimulus(g, "resume");
        waitCycles(70);

        checks++;
        if (fs_count != 2) begin
            errors++;
            $display("[TB] FAIL frame_start_count: got %0d pulses, want 2", fs_count);
        end

        waitCycles(3);
        if (sb.size() != 0) begin
            errors += sb.size();
            checks += sb.size();
            $display("[TB] FAIL scoreboard_drain: got %0d unchecked entries, want 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
